dm_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the single-ported, word-addressed data memory (1024 x 32, combinational read, write at posedge).
- Master 0 is the CPU load/store port; master 1 is a secondary port (debug/DMA loader).
- Serialises requests with round-robin fairness, drives memory control/address/data from registered state, and returns a one-cycle ack with read data.

---
 rtl/dm_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/dm_arbiter.sv | 134 +++++++++++++
 tb/tb_dm_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the two-master data-memory arbiter: state encoding,
// master indices, default widths and the alignment helper.
package dm_arb_pkg;

  localparam int unsigned DefaultAddrW = 32;
  localparam int unsigned DefaultDataW = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StAccess = ACCESS,
    StResp   = RESP
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: combinational select from req and the favoured
// master, with the favoured master handed to the loser after every grant.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       sel
);

  logic prio_q;

  always_comb begin
    sel = M0;
    case (req)
      2'b11:   sel = prio_q;
      2'b10:   sel = M1;
      default: sel = M0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= M0;
    end else if (grant_en) begin
      prio_q <= ~sel;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master sequencer for the single-ported data memory (IDLE -> ACCESS -> RESP).
// Define DM_ARB_ALIGN_CHK_EN to block misaligned accesses and add m0_err/m1_err.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef DM_ARB_ALIGN_CHK_EN
  output logic              m0_err,
  output logic              m1_err,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e state_q;
  logic   sel, sel_q, we_q, mis_q, grant_en;
  logic   win_we, win_mis;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign grant_en = (state_q == StIdle) && (m0_req || m1_req);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .req      ({m1_req, m0_req}),
    .grant_en (grant_en),
    .sel      (sel)
  );

  always_comb begin
    win_we    = (sel == M1) ? m1_we    : m0_we;
    win_addr  = (sel == M1) ? m1_addr  : m0_addr;
    win_wdata = (sel == M1) ? m1_wdata : m0_wdata;
  end

`ifdef DM_ARB_ALIGN_CHK_EN
  assign win_mis = is_misaligned(win_addr[1:0]);
`else
  assign win_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sel_q     <= M0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      busy      <= 1'b0;
`ifdef DM_ARB_ALIGN_CHK_EN
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
`endif
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
`ifdef DM_ARB_ALIGN_CHK_EN
      m0_err <= 1'b0;
      m1_err <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (grant_en) begin
            // Latch the winner here; its inputs are ignored until the next IDLE.
            sel_q     <= sel;
            we_q      <= win_we;
            mis_q     <= win_mis;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_write <= win_we & ~win_mis;
            mem_read  <= ~win_we & ~win_mis;
            busy      <= 1'b1;
            state_q   <= StAccess;
          end
        end
        StAccess: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          if (sel_q == M1) begin
            m1_ack <= 1'b1;
            if (mis_q)      m1_rdata <= '0;
            else if (!we_q) m1_rdata <= mem_rdata;
          end else begin
            m0_ack <= 1'b1;
            if (mis_q)      m0_rdata <= '0;
            else if (!we_q) m0_rdata <= mem_rdata;
          end
`ifdef DM_ARB_ALIGN_CHK_EN
          m0_err <= mis_q && (sel_q == M0);
          m1_err <= mis_q && (sel_q == M1);
`endif
          state_q <= StResp;
        end
        StResp: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a behavioural memory and a
// transaction-level reference model for the randomized run.
module tb_dm_arbiter;

`ifdef DM_ARB_ALIGN_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, busy;
`ifdef DM_ARB_ALIGN_CHK_EN
  logic        m0_err, m1_err;
`endif

  logic [31:0] mem    [1024];
  logic [31:0] shadow [1024];
  int n_checks = 0;
  int n_fail = 0;

  dm_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
`ifdef DM_ARB_ALIGN_CHK_EN
    .m0_err    (m0_err),
    .m1_err    (m1_err),
`endif
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic set_m(input int m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // Leaves the caller just after a negedge with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) << 2;
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    set_m(0, 1'b1, 1'b1, $urandom, $urandom);
    set_m(1, 1'b1, 1'b0, $urandom, $urandom);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, mem_write, mem_read, m0_ack, m1_ack} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, mem_write, mem_read, m0_ack, m1_ack});
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h %h want 0", m0_rdata, m1_rdata);
    end
`ifdef DM_ARB_ALIGN_CHK_EN
    n_checks++;
    if ({m0_err, m1_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 00", {m0_err, m1_err});
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_write_read();
    do_reset();
    mem[4] = 32'h0;
    set_m(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    @(posedge clk); #1;
    n_checks++;
    if ({busy, mem_write, mem_read, m0_ack, m1_ack} !== 5'b11000 || mem_addr !== 32'h10 ||
        mem_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_access: got ctrl=%b addr=%h wdata=%h want 11000 10 deadbeef",
               {busy, mem_write, mem_read, m0_ack, m1_ack}, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, mem_write, mem_read, m0_ack, m1_ack} !== 5'b10010) begin
      n_fail++;
      $display("FAIL wr_ack: got %b want 10010", {busy, mem_write, mem_read, m0_ack, m1_ack});
    end
    n_checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_commit: got %h want deadbeef", mem[4]);
    end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if ({busy, m0_ack, m1_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_resp_end: got %b want 000", {busy, m0_ack, m1_ack});
    end
    @(negedge clk);
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if ({busy, mem_write, mem_read, m0_ack, m1_ack} !== 5'b10100) begin
      n_fail++;
      $display("FAIL rd_access: got %b want 10100", {busy, mem_write, mem_read, m0_ack, m1_ack});
    end
    @(posedge clk); #1;
    n_checks++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_ack: got ack=%b rdata=%h want 1 deadbeef", m0_ack, m0_rdata);
    end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (m0_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_hold: got %h want deadbeef", m0_rdata);
    end
  endtask

  task automatic test_contention();
    logic exp0, exp1;
    do_reset();
    mem[12] = 32'hA0A0_0C0C;
    mem[13] = 32'hB1B1_1D1D;
    set_m(0, 1'b1, 1'b0, 32'h30, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h34, 32'h0);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp0 = (i % 3 == 2) && ((i / 3) % 2 == 0);
      exp1 = (i % 3 == 2) && ((i / 3) % 2 == 1);
      n_checks++;
      if ({m0_ack, m1_ack} !== {exp0, exp1}) begin
        n_fail++;
        $display("FAIL contend_ack edge%0d: got %b want %b", i, {m0_ack, m1_ack}, {exp0, exp1});
      end
    end
    n_checks++;
    if (m0_rdata !== 32'hA0A0_0C0C || m1_rdata !== 32'hB1B1_1D1D) begin
      n_fail++;
      $display("FAIL contend_rdata: got %h %h want a0a00c0c b1b11d1d", m0_rdata, m1_rdata);
    end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_lone_master();
    logic [31:0] data [4];
    int k;
    logic exp1;
    do_reset();
    for (int j = 0; j < 4; j++) data[j] = $urandom;
    k = 0;
    set_m(1, 1'b1, 1'b1, 32'h40, data[0]);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp1 = (i % 3 == 2);
      n_checks++;
      if ({m0_ack, m1_ack} !== {1'b0, exp1}) begin
        n_fail++;
        $display("FAIL lone_ack edge%0d: got %b want %b", i, {m0_ack, m1_ack}, {1'b0, exp1});
      end
      if (i % 3 == 2) begin
        @(negedge clk);
        k++;
        if (k < 4) set_m(1, 1'b1, 1'b1, 32'h40 + 32'(4 * k), data[k]);
        else set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (mem[16 + j] !== data[j]) begin
        n_fail++;
        $display("FAIL lone_mem word%0d: got %h want %h", 16 + j, mem[16 + j], data[j]);
      end
    end
  endtask

  task automatic test_input_change();
    do_reset();
    mem[8]  = 32'h0;
    mem[16] = 32'h5A5A_5A5A;
    set_m(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(posedge clk); #1;
    @(negedge clk);
    set_m(0, 1'b1, 1'b1, 32'h40, 32'h8765_4321);
    @(posedge clk); #1;
    n_checks++;
    if (m0_ack !== 1'b1 || mem_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL chg_ack: got ack=%b addr=%h want 1 20", m0_ack, mem_addr);
    end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++;
    if (mem[8] !== 32'h1234_5678 || mem[16] !== 32'h5A5A_5A5A) begin
      n_fail++;
      $display("FAIL chg_mem: got %h %h want 12345678 5a5a5a5a", mem[8], mem[16]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem[20] = 32'h0BAD_F00D;
    set_m(1, 1'b1, 1'b0, 32'h50, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if ({busy, mem_write, mem_read, m0_ack, m1_ack} !== 5'b10100) begin
      n_fail++;
      $display("FAIL rstmid_access: got %b want 10100",
               {busy, mem_write, mem_read, m0_ack, m1_ack});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, mem_write, mem_read, m0_ack, m1_ack} !== 5'b0 || mem_addr !== 32'h0 ||
        m1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_abort: got ctrl=%b addr=%h rdata=%h want 0",
               {busy, mem_write, mem_read, m0_ack, m1_ack}, mem_addr, m1_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(0, 1'b1, 1'b0, 32'h50, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL rstmid_recover: got ack=%b rdata=%h want 10 0badf00d",
               {m0_ack, m1_ack}, m0_rdata);
    end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_misaligned();
    logic [31:0] want;
    do_reset();
    mem[4] = 32'hA5A5_0000;
    set_m(0, 1'b1, 1'b1, 32'h13, 32'hC0FF_EE11);
    @(posedge clk); #1;
    n_checks++;
    if ({busy, mem_write} !== {1'b1, !ChkEn}) begin
      n_fail++;
      $display("FAIL mis_access: got busy/we=%b want %b", {busy, mem_write}, {1'b1, !ChkEn});
    end
    @(posedge clk); #1;
    n_checks++;
    if (m0_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_ack: got %b want 1", m0_ack);
    end
`ifdef DM_ARB_ALIGN_CHK_EN
    n_checks++;
    if ({m0_err, m1_err} !== 2'b10 || m0_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mis_err: got err=%b rdata=%h want 10 0", {m0_err, m1_err}, m0_rdata);
    end
`endif
    want = ChkEn ? 32'hA5A5_0000 : 32'hC0FF_EE11;
    n_checks++;
    if (mem[4] !== want) begin
      n_fail++;
      $display("FAIL mis_mem: got %h want %h", mem[4], want);
    end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    bit          pend [2];
    bit          p_we [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic [31:0] exp_rd [2];
    int          free_e, gr_edge;
    bit          prio, gm, gwe, gmis, in_acc, in_resp;
    logic [31:0] gaddr, gwdata, exp_maddr, exp_mwdata;
    logic [4:0]  exp_ctrl;
    do_reset();
    free_e = 0; gr_edge = -10; prio = 1'b0; gm = 1'b0; gwe = 1'b0; gmis = 1'b0;
    gaddr = '0; gwdata = '0; exp_maddr = '0; exp_mwdata = '0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; p_we[m] = 1'b0; p_addr[m] = '0; p_wdata[m] = '0; exp_rd[m] = '0;
    end
    for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
    for (int e = 0; e < 360; e++) begin
      if (e != 0) @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        // Granted master scribbles on its inputs during ACCESS; they must be ignored.
        if (pend[m] && e == gr_edge + 1 && gm == 1'(m)) begin
          p_we[m] = ($urandom_range(0, 1) == 1); p_addr[m] = $urandom; p_wdata[m] = $urandom;
        end
        if (pend[m] && e == gr_edge + 2 && gm == 1'(m)) pend[m] = 1'b0;
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m] = 1'b1; p_we[m] = ($urandom_range(0, 1) == 1);
          p_addr[m] = rand_addr(); p_wdata[m] = $urandom;
        end
        set_m(m, pend[m], p_we[m], p_addr[m], p_wdata[m]);
      end
      if (e >= free_e && (pend[0] || pend[1])) begin
        gm = (pend[0] && pend[1]) ? prio : pend[1];
        prio = !gm; gr_edge = e; free_e = e + 3;
        gwe = p_we[gm]; gaddr = p_addr[gm]; gwdata = p_wdata[gm];
        gmis = ChkEn && (gaddr[1:0] != 2'b00);
        exp_maddr = gaddr; exp_mwdata = gwdata;
      end
      @(posedge clk); #1;
      in_acc  = (e == gr_edge);
      in_resp = (e == gr_edge + 1);
      if (in_resp) begin
        if (gmis) exp_rd[gm] = '0;
        else if (!gwe) exp_rd[gm] = shadow[gaddr[11:2]];
        else shadow[gaddr[11:2]] = gwdata;
      end
      exp_ctrl = {in_acc || in_resp, in_acc && gwe && !gmis, in_acc && !gwe && !gmis,
                  in_resp && !gm, in_resp && gm};
      n_checks++;
      if ({busy, mem_write, mem_read, m0_ack, m1_ack} !== exp_ctrl) begin
        n_fail++;
        $display("FAIL rand_ctrl e%0d: got %b want %b", e,
                 {busy, mem_write, mem_read, m0_ack, m1_ack}, exp_ctrl);
      end
      n_checks++;
      if (mem_addr !== exp_maddr || mem_wdata !== exp_mwdata) begin
        n_fail++;
        $display("FAIL rand_bus e%0d: got %h/%h want %h/%h", e, mem_addr, mem_wdata,
                 exp_maddr, exp_mwdata);
      end
      n_checks++;
      if (m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
        n_fail++;
        $display("FAIL rand_rdata e%0d: got %h/%h want %h/%h", e, m0_rdata, m1_rdata,
                 exp_rd[0], exp_rd[1]);
      end
`ifdef DM_ARB_ALIGN_CHK_EN
      n_checks++;
      if ({m0_err, m1_err} !== {in_resp && gmis && !gm, in_resp && gmis && gm}) begin
        n_fail++;
        $display("FAIL rand_err e%0d: got %b", e, {m0_err, m1_err});
      end
`endif
    end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== shadow[i]) begin
        n_fail++;
        $display("FAIL rand_mem word%0d: got %h want %h", i, mem[i], shadow[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    reset = 1'b1;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_write_read();
    test_contention();
    test_lone_master();
    test_input_change();
    test_reset_mid();
    test_misaligned();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
